// File: rtl/clk_monitor_pkg.sv
// Shared types and default configuration for the clk_monitor block.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCK_COUNT_DEF  = 4;
  localparam int TOL_DEF         = 1;
  localparam int TIMEOUT_DEF     = 255;

endpackage

// File: rtl/clk_monitor_edge_sync.sv
// Synchroniser, history flop and registered edge strobes for the monitored clock.
// The unregistered fall indication is only exported when CLK_MON_DUTY_EN is defined.
module edge_sync
  import clk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
`ifdef CLK_MON_DUTY_EN
  output logic fall_o,
`endif
  output logic rise_strobe_o,
  output logic fall_strobe_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_strobe_q;
  logic                   fall_strobe_q;
  logic                   sync_w;
  logic                   rise_w;
  logic                   fall_w;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign rise_w = sync_w & ~hist_q;
  assign fall_w = ~sync_w & hist_q;

  // Shift the async input through the synchroniser, keep one history bit, register strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q        <= '0;
      hist_q        <= 1'b0;
      rise_strobe_q <= 1'b0;
      fall_strobe_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q        <= sync_w;
      rise_strobe_q <= rise_w;
      fall_strobe_q <= fall_w;
    end
  end

  assign rise_o        = rise_w;
`ifdef CLK_MON_DUTY_EN
  assign fall_o        = fall_w;
`endif
  assign rise_strobe_o = rise_strobe_q;
  assign fall_strobe_o = fall_strobe_q;

endmodule

// File: rtl/clk_monitor.sv
// Monitors a slow clock from the fast system clock: edge strobes, rise-to-rise
// period, lock and loss-of-clock status. Define CLK_MON_DUTY_EN to also measure
// the rise-to-fall high time; otherwise highTime is tied to 0.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clkIn,
  input  logic             reset_n,
  input  logic             refClk,
  output logic             riseStrobe,
  output logic             fallStrobe,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             locked,
  output logic             lost
);

  localparam int                     MATCH_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]       TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0]     LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic signed [CNT_W:0]  TOL_C     = (CNT_W+1)'(TOL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // One extra bit keeps the signed difference of two unsigned counts from wrapping
  function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] dev;
    logic signed [CNT_W:0] mag;
    dev = $signed({1'b0, a}) - $signed({1'b0, b});
    mag = dev[CNT_W] ? -dev : dev;
    return mag <= TOL_C;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   prev_q;
  logic               valid_prev_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic               rise_w;
  logic               match_w;
  logic               timeout_w;
`ifdef CLK_MON_DUTY_EN
  logic               fall_w;
`endif

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i        (clkIn),
    .rst_ni       (reset_n),
    .async_i      (refClk),
    .rise_o       (rise_w),
`ifdef CLK_MON_DUTY_EN
    .fall_o       (fall_w),
`endif
    .rise_strobe_o(riseStrobe),
    .fall_strobe_o(fallStrobe)
  );

  assign match_w   = within_tol(cnt_q, prev_q);
  // A rise on the timeout cycle takes priority over the timeout
  assign timeout_w = (cnt_q == TIMEOUT_C) && !rise_w;
  assign cnt_d     = rise_w ? CNT_W'(1) : sat_inc(cnt_q);

  // State register
  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise_w)         state_d = ACQUIRE;
        else if (timeout_w) state_d = LOST;
      end
      ACQUIRE: begin
        if (rise_w) begin
          if (valid_prev_q && match_w && (match_cnt_q == LOCK_LAST)) state_d = LOCKED;
        end else if (timeout_w) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (rise_w) begin
          if (!match_w) state_d = ACQUIRE;
        end else if (timeout_w) begin
          state_d = LOST;
        end
      end
      LOST: begin
        if (rise_w) state_d = ACQUIRE;
      end
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    locked = 1'b0;
    lost   = 1'b0;
    case (state_q)
      LOCKED:  locked = 1'b1;
      LOST:    lost   = 1'b1;
      default: ;
    endcase
  end

  // Period counter, period capture and match tracking, all advanced on detected rises
  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      period_q     <= '0;
      prev_q       <= '0;
      valid_prev_q <= 1'b0;
      match_cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (rise_w) begin
        unique case (state_q)
          IDLE, LOST: begin
            // cnt holds no meaningful period after idle or a timeout
            valid_prev_q <= 1'b0;
            match_cnt_q  <= '0;
          end
          ACQUIRE: begin
            period_q <= cnt_q;
            prev_q   <= cnt_q;
            if (!valid_prev_q)  valid_prev_q <= 1'b1;
            else if (match_w)   match_cnt_q  <= match_cnt_q + MATCH_W'(1);
            else                match_cnt_q  <= '0;
          end
          LOCKED: begin
            period_q <= cnt_q;
            prev_q   <= cnt_q;
            if (!match_w) match_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign period = period_q;

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] high_q;

  // High-time counter restarts on each rise and is captured on the following fall
  always_ff @(posedge clkIn or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= rise_w ? CNT_W'(1) : sat_inc(hcnt_q);
      if (fall_w && (state_q != LOST)) high_q <= hcnt_q;
    end
  end

  assign highTime = high_q;
`else
  assign highTime = '0;
`endif

endmodule
